rd_fifo_interface: RTL

RD_FIFO_INTERFACE -- requirements
Module: rd_fifo_interface

---
 rtl/rd_fifo_interface.sv | 81 ++++++++
 1 files changed

// File: rtl/rd_fifo_interface.sv
// Packs bytes from the flash controller into Read FIFO words, MSB-first.
// A partial word can be flushed and is zero-padded.
module rd_fifo_interface #(
    parameter int RD_FIFO_DATA_WIDTH = 128
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    output logic [RD_FIFO_DATA_WIDTH-1:0] o_rd_fifo_data,
    output logic                          o_rd_fifo_we,
    input  logic                          i_rd_fifo_full,
    input  logic [7:0]                    i_ctrl_data,
    input  logic                          i_ctrl_we,
    input  logic                          i_ctrl_flush,
    output logic                          o_ctrl_full
);

    localparam int NUM_OF_BYTES = RD_FIFO_DATA_WIDTH / 8;
    localparam int IDX_W        = (NUM_OF_BYTES > 1) ? $clog2(NUM_OF_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OF_BYTES - 1);

    typedef enum logic {
        STATE_ACCUMULATE,
        STATE_WRITE_TO_FIFO
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              index_q, index_d;
    logic [RD_FIFO_DATA_WIDTH-1:0] buffer_q, buffer_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= STATE_ACCUMULATE;
            index_q  <= '0;
            buffer_q <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            buffer_q <= buffer_d;
        end
    end

    // Buffer is cleared on every FIFO write, so a flushed word is already zero-padded.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        buffer_d     = buffer_q;
        o_rd_fifo_we = 1'b0;
        o_ctrl_full  = (state_q == STATE_WRITE_TO_FIFO);

        unique case (state_q)
            STATE_ACCUMULATE: begin
                if (i_ctrl_we) begin
                    for (int k = 0; k < NUM_OF_BYTES; k++) begin
                        if (index_q == IDX_W'(k)) begin
                            buffer_d[RD_FIFO_DATA_WIDTH-1-8*k -: 8] = i_ctrl_data;
                        end
                    end
                    if (i_ctrl_flush || (index_q == LAST_IDX)) begin
                        state_d = STATE_WRITE_TO_FIFO;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end else if (i_ctrl_flush && (index_q != '0)) begin
                    state_d = STATE_WRITE_TO_FIFO;
                end
            end
            STATE_WRITE_TO_FIFO: begin
                if (!i_rd_fifo_full) begin
                    o_rd_fifo_we = 1'b1;
                    state_d      = STATE_ACCUMULATE;
                    index_d      = '0;
                    buffer_d     = '0;
                end
            end
            default: state_d = STATE_ACCUMULATE;
        endcase
    end

    assign o_rd_fifo_data = buffer_q;

endmodule
